// File: rtl/stream_upsize_fifo.sv
// Narrow-to-wide stream packer with a first-word-fall-through output buffer; optional idle flush under STREAM_UPSIZE_TIMEOUT_EN.
// Latency: a word-completing beat is visible on m_valid_o one cycle after it is accepted.
// Backpressure: s_ready_o follows FIFO occupancy only; a full buffer stalls every input beat.
module stream_upsize_fifo #(
    parameter int T_DATA_WIDTH   = 8,
    parameter int T_DATA_RATIO   = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH-1:0]              s_data_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_RATIO*T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_DATA_RATIO-1:0]              m_keep_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level_o
);
    localparam int OW = T_DATA_RATIO * T_DATA_WIDTH;
    localparam int CW = $clog2(T_DATA_RATIO);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = OW + T_DATA_RATIO + 1;

    if (T_DATA_RATIO < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("stream_upsize_fifo: illegal parameter set");
    end

    logic [CW-1:0]           cnt;
    logic [OW-1:0]           acc;
    logic [T_DATA_RATIO-1:0] kacc;
    logic [LW-1:0]           level;
    logic                    beat_acc;
    logic                    beat_done;
    logic                    flush;
    logic                    push_vld;
    logic [OW-1:0]           word_dat;
    logic [T_DATA_RATIO-1:0] word_keep;
    logic [EW-1:0]           push_dat;
    logic [EW-1:0]           pop_dat;

    assign s_ready_o = !rst && (level < LW'(FIFO_DEPTH));
    assign beat_acc  = s_valid_i && s_ready_o;
    assign beat_done = beat_acc && (s_last_i || cnt == CW'(T_DATA_RATIO - 1));

    // Current beat merged into the accumulator; unused slots stay zero because acc clears per word.
    always_comb begin
        word_dat  = acc;
        word_keep = kacc;
        word_dat[cnt*T_DATA_WIDTH +: T_DATA_WIDTH] = s_data_i;
        word_keep[cnt] = 1'b1;
    end

`ifdef STREAM_UPSIZE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          idle;

    // The flush fires on the edge that would take the counter to the threshold; it saturates while the FIFO is full.
    assign idle  = (cnt != '0) && !beat_acc;
    assign flush = idle && (idle_cnt >= TW'(TIMEOUT_CYCLES - 1)) && (level < LW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst || beat_acc || flush) begin
            idle_cnt <= '0;
        end else if (idle && idle_cnt < TW'(TIMEOUT_CYCLES - 1)) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    assign push_vld = beat_done || flush;
    assign push_dat = flush ? {1'b0, kacc, acc} : {s_last_i, word_keep, word_dat};

    always_ff @(posedge clk) begin
        if (rst || beat_done || flush) begin
            cnt  <= '0;
            acc  <= '0;
            kacc <= '0;
        end else if (beat_acc) begin
            cnt  <= cnt + CW'(1);
            acc  <= word_dat;
            kacc <= word_keep;
        end
    end

    stream_upsize_fifo_buf #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (m_valid_o),
        .pop_rdy  (m_ready_i),
        .pop_dat  (pop_dat),
        .level    (level)
    );

    assign {m_last_o, m_keep_o, m_data_o} = pop_dat;
    assign fifo_level_o = level;
endmodule

// Generic first-word-fall-through FIFO; head data reads as zero while empty.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: pushes while full are dropped, so the writer must gate on level.
module stream_upsize_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign pop_vld = (level != '0);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;
    assign push    = push_vld && (level < LW'(DEPTH));
    assign pop     = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end
endmodule
